// File: rtl/nmea_pkg.sv
// Shared constants and helpers for the NMEA RMC sentence generator.
package nmea_pkg;

    localparam logic [7:0] AsciiDollar = 8'h24;
    localparam logic [7:0] AsciiComma  = 8'h2C;
    localparam logic [7:0] AsciiStar   = 8'h2A;
    localparam logic [7:0] AsciiDot    = 8'h2E;
    localparam logic [7:0] AsciiCr     = 8'h0D;
    localparam logic [7:0] AsciiLf     = 8'h0A;
    localparam logic [7:0] AsciiZero   = 8'h30;
    localparam logic [7:0] AsciiA      = 8'h41;
    localparam logic [7:0] AsciiV      = 8'h56;
    localparam logic [23:0] AsciiRmc   = 24'h524D43;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StSend = 3'd1;
    localparam logic [2:0] StCsum = 3'd2;
    localparam logic [2:0] StEol  = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    // Index of the status byte, the last byte of the SEND phase.
    localparam logic [4:0] SendLast = 5'd17;

    function automatic logic [7:0] nibble_to_hex_ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/nmea_rmc_gen_if.sv
// Byte stream handshake between the sentence generator and a UART transmitter.
interface nmea_rmc_gen_if;
    logic [7:0] chr;
    logic       valid;
    logic       ready;

    modport master (output chr, output valid, input ready);
    modport slave  (input chr, input valid, output ready);
endinterface

// File: rtl/nmea_bin2dec.sv
// 6-bit binary (0..63) to two ASCII decimal digits, purely combinational.
module nmea_bin2dec
    import nmea_pkg::*;
(
    input  logic [5:0] v,
    output logic [7:0] d1,
    output logic [7:0] d0
);
    logic [5:0] tens;
    logic [5:0] ones;

    assign tens = v / 6'd10;
    assign ones = v % 6'd10;
    assign d1   = AsciiZero + {2'b00, tens};
    assign d0   = AsciiZero + {2'b00, ones};
endmodule

// File: rtl/nmea_rmc_gen.sv
// Formats a latched time/status sample into "$<TALKER>RMC,HHMMSS.00,S[*CC]\r\n", one byte per
// transfer. Define NMEA_CHECKSUM_EN to emit the "*CC" checksum field.
module nmea_rmc_gen
    import nmea_pkg::*;
#(
    parameter logic [15:0] TALKER_ID = 16'h4750
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] hr,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       fix_ok,
    output logic       busy,
    output logic       done,
    nmea_rmc_gen_if.master tx
);
    logic [2:0] state_q;
    logic [4:0] idx_q;
    logic [4:0] hr_q;
    logic [5:0] min_q;
    logic [5:0] sec_q;
    logic [7:0] status_q;
`ifdef NMEA_CHECKSUM_EN
    logic [7:0] csum_q;
`endif

    logic [7:0] h1, h0, m1, m0, s1, s0;
    logic       xfer;
    logic       in_range;

    nmea_bin2dec u_hr  (.v({1'b0, hr_q}), .d1(h1), .d0(h0));
    nmea_bin2dec u_min (.v(min_q),        .d1(m1), .d0(m0));
    nmea_bin2dec u_sec (.v(sec_q),        .d1(s1), .d0(s0));

    assign in_range = (hr <= 5'd23) && (min <= 6'd59) && (sec <= 6'd59);
    assign xfer     = tx.valid && tx.ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            hr_q     <= '0;
            min_q    <= '0;
            sec_q    <= '0;
            status_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        hr_q     <= hr;
                        min_q    <= min;
                        sec_q    <= sec;
                        status_q <= (fix_ok && in_range) ? AsciiA : AsciiV;
                        idx_q    <= '0;
                        state_q  <= StSend;
                    end
                end
                StSend: begin
                    if (xfer) begin
                        if (idx_q == SendLast) begin
                            idx_q <= '0;
`ifdef NMEA_CHECKSUM_EN
                            state_q <= StCsum;
`else
                            state_q <= StEol;
`endif
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
`ifdef NMEA_CHECKSUM_EN
                StCsum: begin
                    if (xfer) begin
                        if (idx_q == 5'd2) begin
                            idx_q   <= '0;
                            state_q <= StEol;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
`endif
                StEol: begin
                    if (xfer) begin
                        if (idx_q == 5'd1) begin
                            idx_q   <= '0;
                            state_q <= StDone;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef NMEA_CHECKSUM_EN
    // '$' (index 0) is excluded from the checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (state_q == StIdle && start) begin
            csum_q <= '0;
        end else if (state_q == StSend && xfer && idx_q != 5'd0) begin
            csum_q <= csum_q ^ tx.chr;
        end
    end
`endif

    always_comb begin
        tx.chr   = 8'h00;
        tx.valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            StSend: begin
                tx.valid = 1'b1;
                busy     = 1'b1;
                case (idx_q)
                    5'd0:    tx.chr = AsciiDollar;
                    5'd1:    tx.chr = TALKER_ID[15:8];
                    5'd2:    tx.chr = TALKER_ID[7:0];
                    5'd3:    tx.chr = AsciiRmc[23:16];
                    5'd4:    tx.chr = AsciiRmc[15:8];
                    5'd5:    tx.chr = AsciiRmc[7:0];
                    5'd6:    tx.chr = AsciiComma;
                    5'd7:    tx.chr = h1;
                    5'd8:    tx.chr = h0;
                    5'd9:    tx.chr = m1;
                    5'd10:   tx.chr = m0;
                    5'd11:   tx.chr = s1;
                    5'd12:   tx.chr = s0;
                    5'd13:   tx.chr = AsciiDot;
                    5'd14:   tx.chr = AsciiZero;
                    5'd15:   tx.chr = AsciiZero;
                    5'd16:   tx.chr = AsciiComma;
                    default: tx.chr = status_q;
                endcase
            end
`ifdef NMEA_CHECKSUM_EN
            StCsum: begin
                tx.valid = 1'b1;
                busy     = 1'b1;
                case (idx_q)
                    5'd0:    tx.chr = AsciiStar;
                    5'd1:    tx.chr = nibble_to_hex_ascii(csum_q[7:4]);
                    default: tx.chr = nibble_to_hex_ascii(csum_q[3:0]);
                endcase
            end
`endif
            StEol: begin
                tx.valid = 1'b1;
                busy     = 1'b1;
                tx.chr   = (idx_q == 5'd0) ? AsciiCr : AsciiLf;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_nmea_rmc_gen.sv
// Directed bench for nmea_rmc_gen; expected sentences come from literals and a small model.
`timescale 1ns/1ps
module tb_nmea_rmc_gen;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] hr = '0;
    logic [5:0] min = '0;
    logic [5:0] sec = '0;
    logic       fix_ok = 1'b0;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

`ifdef NMEA_CHECKSUM_EN
    localparam int DoneCyc = 24;
    localparam string Exp1  = "$GPRMC,123456.00,A*23\r\n";
    localparam string Exp2a = "$GPRMC,000000.00,A*24\r\n";
    localparam string Exp2v = "$GPRMC,000000.00,V*33\r\n";
`else
    localparam int DoneCyc = 21;
    localparam string Exp1  = "$GPRMC,123456.00,A\r\n";
    localparam string Exp2a = "$GPRMC,000000.00,A\r\n";
    localparam string Exp2v = "$GPRMC,000000.00,V\r\n";
`endif

    nmea_rmc_gen_if tx_if ();

    nmea_rmc_gen #(.TALKER_ID(16'h4750)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .hr     (hr),
        .min    (min),
        .sec    (sec),
        .fix_ok (fix_ok),
        .busy   (busy),
        .done   (done),
        .tx     (tx_if.master)
    );

    always #5 clk = ~clk;

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic string q2str(input bq_t q);
        string s = "";
        foreach (q[i]) begin
            if (q[i] == 8'h0D)      s = {s, "<CR>"};
            else if (q[i] == 8'h0A) s = {s, "<LF>"};
            else                    s = $sformatf("%s%c", s, q[i]);
        end
        return s;
    endfunction

    function automatic bq_t model(input int h, input int m, input int s, input bit fix);
        bq_t q;
        logic [7:0] cs = 8'h00;
        byte st;
        string body;
        st = (fix && h <= 23 && m <= 59 && s <= 59) ? "A" : "V";
        body = $sformatf("GPRMC,%02d%02d%02d.00,%c", h, m, s, st);
        q.push_back(8'h24);
        for (int i = 0; i < body.len(); i++) begin
            q.push_back(body[i]);
            cs = cs ^ body[i];
        end
`ifdef NMEA_CHECKSUM_EN
        body = $sformatf("*%02X", cs);
        for (int i = 0; i < body.len(); i++) q.push_back(body[i]);
`endif
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    task automatic do_start(input int h, input int m, input int s, input bit fix);
        @(negedge clk);
        hr = 5'(h); min = 6'(m); sec = 6'(s); fix_ok = fix;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples at negedges starting at the first cycle after the start cycle.
    task automatic capture(input bit rand_ready, input bit hammer, input int abort_at,
                           output bq_t got, output int done_cyc, output int stall_err,
                           output bit first_busy);
        bit pstall = 1'b0;
        logic [7:0] pchr = '0;
        bit r;
        got = {};
        done_cyc = -1;
        stall_err = 0;
        first_busy = busy;
        for (int c = 1; c <= 200; c++) begin
            if (pstall && (tx_if.valid !== 1'b1 || tx_if.chr !== pchr)) stall_err++;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (abort_at >= 0 && got.size() == abort_at) begin
                rst = 1'b1;
                break;
            end
            r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tx_if.ready = r;
            if (tx_if.valid === 1'b1 && r) got.push_back(tx_if.chr);
            pstall = (tx_if.valid === 1'b1) && !r;
            pchr = tx_if.chr;
            if (hammer) begin
                start = 1'b1;
                hr = 5'($urandom_range(0, 31));
                min = 6'($urandom_range(0, 63));
                sec = 6'($urandom_range(0, 63));
                fix_ok = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        tx_if.ready = 1'b1;
    endtask

    task automatic cmp_seq(input string name, input bq_t got, input bq_t exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, q2str(got), q2str(exp));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_if.ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", tx_if.valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (tx_if.chr !== 8'h00) begin errors++; $display("FAIL reset_char: got %h expected 00", tx_if.chr); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bq_t got; int dc, se; bit fb;
        do_start(12, 34, 56, 1'b1);
        capture(1'b0, 1'b0, -1, got, dc, se, fb);
        cmp_seq("basic_seq", got, str2q(Exp1));
        checks++;
        if (dc != DoneCyc) begin errors++; $display("FAIL basic_done_cycle: got %0d expected %0d", dc, DoneCyc); end
        checks++;
        if (fb !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", fb); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL basic_after_done: busy %b done %b expected 0 0", busy, done);
        end
    endtask

    task automatic test_zero_time();
        bq_t got; int dc, se; bit fb;
        do_start(0, 0, 0, 1'b1);
        capture(1'b0, 1'b0, -1, got, dc, se, fb);
        cmp_seq("zero_fix_a", got, str2q(Exp2a));
        do_start(0, 0, 0, 1'b0);
        capture(1'b0, 1'b0, -1, got, dc, se, fb);
        cmp_seq("zero_fix_v", got, str2q(Exp2v));
    endtask

    task automatic test_out_of_range();
        bq_t got, exp; int dc, se; bit fb;
        do_start(25, 0, 0, 1'b1);
        capture(1'b0, 1'b0, -1, got, dc, se, fb);
        exp = model(25, 0, 0, 1'b1);
        cmp_seq("hr25_seq", got, exp);
        checks++;
        if (got.size() < 18 || got[17] !== 8'h56) begin
            errors++; $display("FAIL hr25_status: got %s expected V", q2str(got));
        end
        do_start(7, 60, 5, 1'b1);
        capture(1'b0, 1'b0, -1, got, dc, se, fb);
        cmp_seq("min60_seq", got, model(7, 60, 5, 1'b1));
    endtask

    task automatic test_backpressure();
        bq_t got; int dc, se; bit fb;
        do_start(12, 34, 56, 1'b1);
        capture(1'b1, 1'b0, -1, got, dc, se, fb);
        cmp_seq("bp_seq", got, str2q(Exp1));
        checks++;
        if (se != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d unstable stalls expected 0", se); end
    endtask

    task automatic test_start_while_busy();
        bq_t got; int dc, se; bit fb;
        do_start(12, 34, 56, 1'b1);
        capture(1'b0, 1'b1, -1, got, dc, se, fb);
        cmp_seq("hammer_seq", got, str2q(Exp1));
        // start is still high through the done cycle and must be ignored
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (tx_if.valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL hammer_idle: valid %b busy %b expected 0 0", tx_if.valid, busy);
        end
        @(negedge clk);
        checks++;
        if (tx_if.valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL hammer_idle2: valid %b busy %b expected 0 0", tx_if.valid, busy);
        end
    endtask

    task automatic test_mid_reset();
        bq_t got; int dc, se; bit fb;
        do_start(12, 34, 56, 1'b1);
        capture(1'b0, 1'b0, 9, got, dc, se, fb);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (tx_if.valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst: valid %b busy %b expected 0 0", tx_if.valid, busy);
        end
        do_start(9, 8, 7, 1'b0);
        capture(1'b0, 1'b0, -1, got, dc, se, fb);
        cmp_seq("after_rst_seq", got, model(9, 8, 7, 1'b0));
    endtask

    initial begin
        tx_if.ready = 1'b1;
        test_reset();
        test_basic();
        test_zero_time();
        test_out_of_range();
        test_backpressure();
        test_start_while_busy();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
